// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N decoder with enable.
//   Direct mode decodes a loaded index and holds it.
//   Scan mode moves the active output through all 2^N positions. Each
//   position is held for DIV cycles. A scan runs either continuously or
//   as a single pass that ends with a one-cycle done pulse.
// Optional feature macro: SCAN_DECODER_THERMO_EN. It adds a 'thermo'
// input, latched on each accepted load. When set, y shows a thermometer
// code (y[i] = 1 for i <= idx) instead of a one-hot code.
module scan_decoder #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [1:0]          mode,
  input  logic [N-1:0]        w,
`ifdef SCAN_DECODER_THERMO_EN
  input  logic                thermo,
`endif
  output logic [(1<<N)-1:0]   y,
  output logic [N-1:0]        idx,
  output logic                busy,
  output logic                done
);

  localparam int YW = 1 << N;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_CONT   = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [N-1:0]    start_q, start_d;   // first scan position; single pass ends one before it
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            single_q, single_d; // scan type latched on entry
  logic [YW-1:0]   y_q, y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            thermo_q, thermo_d;
  logic            thermo_in;
  logic [N-1:0]    idx_inc;
  logic [YW-1:0]   onehot_d;

`ifdef SCAN_DECODER_THERMO_EN
  assign thermo_in = thermo;
`else
  assign thermo_in = 1'b0;
`endif

  assign idx_inc = idx_q + N'(1);

  // Next-state, next-index and next-output logic.
  // Outputs come from the next state, so y and idx change on the same edge.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default value first.
    // Without the defaults, a path that skips an assignment would infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    start_d  = start_q;
    dwell_d  = dwell_q;
    single_d = single_q;
    thermo_d = thermo_q;
    done_d   = 1'b0;

    if (!en) begin
      // en low always wins. It aborts a scan with no done pulse, and idx keeps its value.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DIRECT: begin
          if (load) begin
            if (mode == MODE_DIRECT) begin
              state_d  = ST_DIRECT;
              idx_d    = w;
              thermo_d = thermo_in;
            end else if (mode == MODE_CONT || mode == MODE_SINGLE) begin
              state_d  = ST_SCAN;
              idx_d    = w;
              start_d  = w;
              dwell_d  = '0;
              single_d = (mode == MODE_SINGLE);
              thermo_d = thermo_in;
            end
            // Reserved mode: the load is ignored.
          end
        end
        ST_SCAN: begin
          // load, mode and w are ignored until the scan finishes.
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (single_q && (idx_inc == start_q)) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_inc;
            end
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    onehot_d = YW'(1) << idx_d;
    y_d      = onehot_d;
    if (thermo_d) begin
      // Bits 0..idx set. (onehot << 1) is zero at the top index, so this becomes all ones.
      y_d = (onehot_d << 1) - YW'(1);
    end
    if (state_d == ST_IDLE) begin
      y_d = '0;
    end
    busy_d = (state_d == ST_SCAN);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      start_q  <= '0;
      dwell_q  <= '0;
      single_q <= 1'b0;
      thermo_q <= 1'b0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignments for registers. All registers then
      // update together from the values they had before the edge.
      state_q  <= state_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      dwell_q  <= dwell_d;
      single_q <= single_d;
      thermo_q <= thermo_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder (N=3, DIV=4).
// The reference model works from time: while scanning, the expected index
// is start + (edges since entry)/DIV, taken modulo 2^N.
module tb_scan_decoder;

  localparam int N   = 3;
  localparam int DIV = 4;
  localparam int YW  = 1 << N;
  localparam int PASS_LEN = YW * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [N-1:0]  w = '0;
  logic          th = 1'b0;
  logic [YW-1:0] y;
  logic [N-1:0]  idx;
  logic          busy;
  logic          done;

  int n_pass  = 0;
  int n_total = 0;

  scan_decoder #(.N(N), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .load  (load),
    .mode  (mode),
    .w     (w),
`ifdef SCAN_DECODER_THERMO_EN
    .thermo(th),
`endif
    .y     (y),
    .idx   (idx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int  m_k;        // edge counter
  bit  m_on;       // outputs enabled (direct or scanning)
  bit  m_scan;
  bit  m_single;
  bit  m_thermo;
  int  m_idx;
  int  m_start;
  int  m_t0;       // edge at which the scan was entered
  bit  m_done;

  task automatic model_reset();
    m_on = 0; m_scan = 0; m_single = 0; m_thermo = 0;
    m_idx = 0; m_start = 0; m_t0 = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit e, input bit l, input int m, input int wv, input bit t);
    int el;
    m_k++;
    m_done = 0;
    if (!e) begin
      m_on = 0;
      m_scan = 0;
    end else if (m_scan) begin
      el = m_k - m_t0;
      if (m_single && el >= PASS_LEN) begin
        m_on = 0; m_scan = 0; m_done = 1;
        m_idx = (m_start + YW - 1) % YW;
      end else begin
        m_idx = (m_start + el / DIV) % YW;
      end
    end else if (l && m != 3) begin
      m_on = 1;
      m_idx = wv;
      m_thermo = t;
      if (m != 0) begin
        m_scan = 1; m_single = (m == 2); m_start = wv; m_t0 = m_k;
      end
    end
  endtask

  function automatic logic [YW-1:0] model_y();
    logic [YW-1:0] r;
    for (int i = 0; i < YW; i++)
      r[i] = m_on && (m_thermo ? (i <= m_idx) : (i == m_idx));
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive inputs, take one edge, then compare every output against the model.
  task automatic tick(input bit e, input bit l, input logic [1:0] m, input logic [N-1:0] wv);
    en = e; load = l; mode = m; w = wv;
    @(posedge clk);
    #1;
    model_edge(e, l, int'(m), int'(wv), th);
    check($sformatf("y@%0d", m_k), 64'(y), 64'(model_y()));
    check($sformatf("idx@%0d", m_k), 64'(idx), 64'(m_idx));
    check($sformatf("busy@%0d", m_k), 64'(busy), 64'(m_scan));
    check($sformatf("done@%0d", m_k), 64'(done), 64'(m_done));
  endtask

  function automatic logic [1:0] rnd_mode();
    return 2'($urandom);
  endfunction

  function automatic logic [N-1:0] rnd_w();
    return N'($urandom);
  endfunction

  initial begin
    int busy_cnt;
    int done_cnt;
    model_reset();
    m_k = 0;

    // Reset state.
    #12;
    check("rst_y", 64'(y), 64'd0);
    check("rst_idx", 64'(idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Direct loads.
    tick(1, 1, 2'b00, 3'd5);
    check("direct_w5", 64'(y), 64'h20);
    tick(1, 1, 2'b00, 3'd2);
    check("direct_w2", 64'(y), 64'h04);
    tick(1, 0, 2'b00, 3'd0);
    tick(1, 0, 2'b01, 3'd7);
    tick(1, 1, 2'b11, 3'd6);   // reserved mode while in direct is ignored
    check("direct_rsvd_idx", 64'(idx), 64'd2);
    tick(0, 0, 2'b00, 3'd0);
    check("en_low_y", 64'(y), 64'd0);
    tick(1, 0, 2'b00, 3'd3);
    tick(1, 0, 2'b00, 3'd3);
    check("idle_hold_y", 64'(y), 64'd0);

    // Single-pass scan from 6. Random load pulses during the scan must be ignored.
    tick(1, 1, 2'b10, 3'd6);
    check("single_first", 64'(y), 64'h40);
    busy_cnt = int'(busy);
    for (int c = 0; c < PASS_LEN - 1; c++) begin
      tick(1, $urandom_range(0, 3) == 0, rnd_mode(), rnd_w());
      busy_cnt += int'(busy);
    end
    check("single_busy_len", 64'(busy_cnt), 64'(PASS_LEN));
    tick(1, 0, 2'b00, 3'd0);
    check("single_done", 64'(done), 64'd1);
    check("single_end_y", 64'(y), 64'd0);
    check("single_end_idx", 64'(idx), 64'd5);
    tick(1, 0, 2'b00, 3'd0);
    check("single_done_pulse", 64'(done), 64'd0);

    // Continuous scan from 0, with en dropped on cycle 45.
    done_cnt = 0;
    tick(1, 1, 2'b01, 3'd0);
    for (int c = 1; c < 45; c++) begin
      tick(1, $urandom_range(0, 3) == 0, rnd_mode(), rnd_w());
      done_cnt += int'(done);
      if (c == PASS_LEN) check("cont_wrap", 64'(idx), 64'd0);
    end
    check("cont_no_done", 64'(done_cnt), 64'd0);
    tick(0, 0, 2'b00, 3'd0);
    check("cont_abort_y", 64'(y), 64'd0);
    check("cont_abort_busy", 64'(busy), 64'd0);
    check("cont_abort_done", 64'(done), 64'd0);

    // Randomized mix of loads, modes and en drops.
    for (int c = 0; c < 400; c++) begin
      tick($urandom_range(0, 24) != 0, $urandom_range(0, 5) == 0, rnd_mode(), rnd_w());
    end

    // Asynchronous reset between edges during a scan.
    tick(1, 1, 2'b01, 3'd3);
    for (int c = 0; c < 5; c++) tick(1, 0, 2'b00, 3'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", 64'(y), 64'd0);
    check("async_rst_idx", 64'(idx), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    model_reset();
    @(posedge clk); #3;
    rst_n = 1'b1;
    tick(1, 1, 2'b11, 3'd4);
    check("rsvd_idle_idx", 64'(idx), 64'd0);
    check("rsvd_idle_y", 64'(y), 64'd0);

`ifdef SCAN_DECODER_THERMO_EN
    th = 1'b1;
    tick(1, 1, 2'b00, 3'd3);
    check("thermo_direct", 64'(y), 64'h0F);
    tick(1, 1, 2'b10, 3'd7);
    check("thermo_scan_first", 64'(y), 64'hFF);
    th = 1'b0;
    for (int c = 0; c < DIV - 1; c++) tick(1, 0, 2'b00, 3'd0);
    tick(1, 0, 2'b00, 3'd0);
    check("thermo_scan_next", 64'(y), 64'h01);
    for (int c = 0; c < PASS_LEN; c++) tick(1, $urandom_range(0, 3) == 0, rnd_mode(), rnd_w());
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
